paint_write_scheduler: RTL and testbench
========================================

# paint_write_scheduler

Sequences all writes into the half-resolution paint framebuffer (320x240, 24-bit RGB). Turns a cursor "paint" request into a BLK x BLK pixel block write and a "clear" request into a full-buffer sweep. It arbitrates between the two request sources and exposes a single write port toward the framebuffer RAM. It sits between the cursor/button logic and the framebuffer; the VGA read side is untouched.

## Interface

Parameters:
- FB_W, 320: framebuffer width in pixels.
- FB_H, 240: framebuffer height in pixels.
- BLK, 8: painted block edge in framebuffer pixels (16 screen pixels).
- ADDR_W, 17: framebuffer address width (FB_W*FB_H = 76800 < 2^17).
- CLEAR_COLOR, 24'h000000: data written by the clear sweep.

Ports:
- CLOCK_50  in  1  sole clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clock and reset fixed as already decided.
- paint_req  in  1  request to paint one block; sampled each posedge.
- cursor_x  in  11  cursor screen X (0..639); sampled on paint acceptance.
- cursor_y  in  11  cursor screen Y (0..479); sampled on paint acceptance.
- paint_color  in  24  {R,G,B}; sampled on paint acceptance.
- clear_req  in  1  request to clear the whole buffer.
- busy  out  1  high while in PAINT or CLEAR.
- done  out  1  one-cycle pulse when a job finishes.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  ADDR_W  write address = y*FB_W + x.
- fb_data  out  24  write data.

## Operation

- States: IDLE, PAINT, CLEAR. All outputs are registered.
- IDLE decision priority: clear_req (or pend_clear) first; otherwise paint_req (or pend_paint).
- Paint acceptance captures bx = cursor_x>>1, by = cursor_y>>1 and paint_color, resets dx = dy = 0, then enters PAINT.
- PAINT runs exactly BLK*BLK cycles, raster order: dx increments fastest, dy increments on dx wrap.
  - Each cycle targets px = bx+dx, py = by+dy.
  - If px < FB_W and py < FB_H: fb_we=1, fb_addr = py*FB_W+px, fb_data = captured color.
  - Otherwise fb_we=0 (clipped) and counters still advance. No wrap-around to the opposite edge.
  - After the final pixel: done=1, go to IDLE.
- CLEAR writes fb_addr 0..FB_W*FB_H-1, one per cycle, with fb_data = CLEAR_COLOR and fb_we=1. Then done=1, go to IDLE.
- Requests arriving while busy:
  - paint_req during PAINT sets pend_paint. The queue is one deep; extra requests are dropped.
  - clear_req during PAINT sets pend_clear.
  - paint_req and clear_req during CLEAR are dropped.
  - Entering CLEAR discards pend_paint.
- Address arithmetic must be exact for all in-range pixels. It may be incremental (row-base register plus dx); no wrap inside ADDR_W.
- fb_we=0 whenever not in PAINT or CLEAR. fb_addr and fb_data hold their last value; they are 0 after reset.
- Reset values: busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, pend_paint=0, pend_clear=0, state=IDLE.
- Reset asserted mid-job: all of the above take effect immediately (asynchronously). The job is abandoned and no done is produced.

## Timing

- Request sampled high at edge N in IDLE: busy=1 from edge N+1.
- Paint:
  - first write presented from edge N+1;
  - last write from edge N+BLK*BLK (N+64 by default);
  - done=1 and busy=0 from edge N+65 for exactly one cycle.
- Clear: writes from edges N+1..N+76800; done and busy-fall at edge N+76801.
- A pending request, or a request held high, is accepted at the edge where done rises. Its first write appears at the next edge, so jobs run back-to-back with one idle cycle.
- done never coincides with fb_we=1.
- Level-held paint_req repaints continuously. Upstream issues single-cycle pulses.

## Test plan

- Basic paint: after reset, cursor=(312,232), color=24'h006400, one-cycle paint_req at edge N.
  - Required: 64 writes on consecutive cycles.
  - First fb_addr=37276 (116*320+156); 8th write at 37283; 9th at 37596; last at 39523.
  - done pulse at N+65.
- Edge clipping: cursor=(636,478), giving bx=318, by=239.
  - Required: fb_we=1 only at addr 76798 and 76799 (cycles N+1, N+2); fb_we=0 on the other 62 cycles.
  - done still at N+65; no address ≥76800 ever written.
- Clear sweep: clear_req pulse.
  - Required: 76800 writes, addr 0..76799 ascending, data 24'h000000, busy high throughout, done at N+76801.
- Arbitration: clear_req and paint_req high on the same edge in IDLE.
  - Required: CLEAR runs; the paint is dropped; no paint writes after done.
- Queuing: during a paint, pulse paint_req at N+10 and clear_req at N+20.
  - Required: the second paint is accepted at N+65 with writes N+66..N+129.
  - Then clear_req at N+20 leaves pend_clear set, so CLEAR wins over any later paint at the next IDLE.
- Async reset mid-clear: assert reset between edges during CLEAR at addr≈1000.
  - Required: fb_we, busy and done drop to 0 without waiting for an edge; no done pulse.
  - After release, a paint at (0,0) writes addr 0 first and completes normally.

Source files
------------

// File: rtl/paint_write_scheduler.sv
// Write-port sequencer for the half-resolution paint framebuffer: turns cursor
// paint requests into clipped BLKxBLK block writes and clear requests into a full sweep.
module paint_write_scheduler #(
  parameter int          FB_W        = 320,
  parameter int          FB_H        = 240,
  parameter int          BLK         = 8,
  parameter int          ADDR_W      = 17,
  parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              paint_req,
  input  logic [10:0]       cursor_x,
  input  logic [10:0]       cursor_y,
  input  logic [23:0]       paint_color,
  input  logic              clear_req,
  output logic              busy,
  output logic              done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data
);

  localparam int CW   = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int RB_W = ADDR_W + 4;
  localparam int NPIX = FB_W * FB_H;

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

  state_t            state;
  logic [10:0]       bx, by;
  logic [CW-1:0]     dx, dy;
  logic [RB_W-1:0]   row_base;
  logic [23:0]       color;
  logic [ADDR_W-1:0] caddr;
  logic              fin, pend_paint, pend_clear;

  logic [10:0] px, py;
  logic        in_fb, blk_last, dx_last, start_clear, start_paint;

  assign px       = bx + 11'(dx);
  assign py       = by + 11'(dy);
  assign in_fb    = (px < 11'(FB_W)) && (py < 11'(FB_H));
  assign dx_last  = (dx == CW'(BLK - 1));
  assign blk_last = dx_last && (dy == CW'(BLK - 1));

  // At the end of a paint, a queued paint goes first (it was queued earlier);
  // a queued clear stays pending and wins at the following decision point.
  always_comb begin
    start_clear = 1'b0;
    start_paint = 1'b0;
    if (state == PAINT) begin
      start_paint = pend_paint || (!pend_clear && !clear_req && paint_req);
      start_clear = !pend_paint && (pend_clear || clear_req);
    end else begin
      start_clear = clear_req || pend_clear;
      start_paint = !start_clear && (paint_req || pend_paint);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      pend_paint <= 1'b0;
      pend_clear <= 1'b0;
      fin        <= 1'b0;
      bx         <= '0;
      by         <= '0;
      dx         <= '0;
      dy         <= '0;
      row_base   <= '0;
      color      <= '0;
      caddr      <= '0;
    end else begin
      done  <= 1'b0;
      fb_we <= 1'b0;
      if (state == IDLE || fin) begin
        busy <= 1'b0;
        fin  <= 1'b0;
        done <= (state != IDLE);
        if (start_clear) begin
          state      <= CLEAR;
          caddr      <= '0;
          pend_paint <= 1'b0;
          pend_clear <= 1'b0;
        end else if (start_paint) begin
          state      <= PAINT;
          bx         <= cursor_x >> 1;
          by         <= cursor_y >> 1;
          color      <= paint_color;
          dx         <= '0;
          dy         <= '0;
          row_base   <= RB_W'(cursor_y >> 1) * RB_W'(FB_W);
          pend_paint <= 1'b0;
          pend_clear <= pend_clear | clear_req;
        end else begin
          state <= IDLE;
        end
      end else if (state == PAINT) begin
        busy       <= 1'b1;
        fb_we      <= in_fb;
        pend_paint <= pend_paint | paint_req;
        pend_clear <= pend_clear | clear_req;
        if (in_fb) begin
          fb_addr <= ADDR_W'(row_base + RB_W'(px));
          fb_data <= color;
        end
        // row_base tracks (by+dy)*FB_W so no multiplier sits in the pixel loop
        if (blk_last) begin
          fin <= 1'b1;
        end else if (dx_last) begin
          dx       <= '0;
          dy       <= dy + CW'(1);
          row_base <= row_base + RB_W'(FB_W);
        end else begin
          dx <= dx + CW'(1);
        end
      end else begin
        busy    <= 1'b1;
        fb_we   <= 1'b1;
        fb_addr <= caddr;
        fb_data <= CLEAR_COLOR;
        if (caddr == ADDR_W'(NPIX - 1)) fin <= 1'b1;
        else caddr <= caddr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_paint_write_scheduler.sv
// Bench for paint_write_scheduler: table of paint vectors plus queuing,
// async-reset and full-clear sequences, all writes checked through a scoreboard.
module tb_paint_write_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        paint_req = 1'b0;
  logic [10:0] cursor_x = '0;
  logic [10:0] cursor_y = '0;
  logic [23:0] paint_color = '0;
  logic        clear_req = 1'b0;
  logic        busy, done, fb_we;
  logic [16:0] fb_addr;
  logic [23:0] fb_data;

  paint_write_scheduler dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .paint_req(paint_req),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .paint_color(paint_color),
    .clear_req(clear_req), .busy(busy), .done(done), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int cx; int cy; int col; int first; int n; } vec_t;

  wr_t sb[$];
  int  total = 0, bad = 0;
  int  cyc = 0;
  int  nwr = 0, first_addr = -1, first_cyc = -1;

  always @(posedge CLOCK_50) cyc++;

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Independent reference: direct y*320+x for every unclipped block pixel.
  task automatic push_paint(int cx, int cy, int col);
    wr_t w;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        if ((cx / 2 + x) < 320 && (cy / 2 + y) < 240) begin
          w.addr = (cy / 2 + y) * 320 + (cx / 2 + x);
          w.data = col;
          sb.push_back(w);
        end
      end
  endtask

  task automatic push_clear(int n);
    wr_t w;
    for (int a = 0; a < n; a++) begin
      w.addr = a;
      w.data = 0;
      sb.push_back(w);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (done) check("we_during_done", int'(fb_we), 0);
      if (fb_we) begin
        wr_t e;
        nwr++;
        if (nwr == 1) begin
          first_addr = int'(fb_addr);
          first_cyc  = cyc;
        end
        if (sb.size() == 0) begin
          check("unexpected_write_addr", int'(fb_addr), -1);
        end else begin
          e = sb.pop_front();
          check("wr_addr", int'(fb_addr), e.addr);
          check("wr_data", int'(fb_data), e.data);
        end
      end
    end
  end

  task automatic issue(bit p, bit c, int cx, int cy, int col, output int n);
    @(negedge CLOCK_50);
    cursor_x    = 11'(cx);
    cursor_y    = 11'(cy);
    paint_color = 24'(col);
    paint_req   = p;
    clear_req   = c;
    n = cyc + 1;
    @(negedge CLOCK_50);
    paint_req = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wait_done(string nm, int budget, output int dc, output int busy_ok);
    dc = -1;
    busy_ok = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_50);
      if (done) begin
        dc = cyc;
        break;
      end
      if (!busy) busy_ok = 0;
    end
    if (dc < 0) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_paint(string nm, vec_t v);
    int n, dc, bok;
    nwr = 0;
    push_paint(v.cx, v.cy, v.col);
    issue(1'b1, 1'b0, v.cx, v.cy, v.col, n);
    wait_done(nm, 100, dc, bok);
    check({nm, "_done_cycle"}, dc - n, 65);
    check({nm, "_busy_high"}, bok, 1);
    check({nm, "_busy_at_done"}, int'(busy), 0);
    check({nm, "_nwrites"}, nwr, v.n);
    if (v.n > 0) begin
      check({nm, "_first_cycle"}, first_cyc - n, 1);
      check({nm, "_first_addr"}, first_addr, v.first);
    end
    check({nm, "_sb_left"}, sb.size(), 0);
    repeat (2) @(negedge CLOCK_50);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int n0, n1, n2, d1, d2, bok, hit;

    tbl[0] = '{cx: 312,  cy: 232, col: 'h006400, first: 37276, n: 64};
    tbl[1] = '{cx: 636,  cy: 478, col: 'hABCDEF, first: 76798, n: 2};
    tbl[2] = '{cx: 639,  cy: 0,   col: 'h123456, first: 319,   n: 8};
    tbl[3] = '{cx: 0,    cy: 479, col: 'hFF0000, first: 76480, n: 8};
    tbl[4] = '{cx: 1,    cy: 3,   col: 'h00FF00, first: 320,   n: 64};
    tbl[5] = '{cx: 2000, cy: 100, col: 'h0000FF, first: 0,     n: 0};

    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(fb_we), 0);
    check("rst_addr", int'(fb_addr), 0);
    check("rst_data", int'(fb_data), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    for (int i = 0; i < 6; i++) run_paint($sformatf("paint%0d", i), tbl[i]);

    // Queuing: paint at N, paint at N+10, clear at N+20.
    nwr = 0;
    push_paint(100, 100, 'h445566);
    push_paint(200, 50, 'h778899);
    push_clear(1100);
    issue(1'b1, 1'b0, 100, 100, 'h445566, n0);
    repeat (8) @(negedge CLOCK_50);
    issue(1'b1, 1'b0, 200, 50, 'h778899, n1);
    repeat (8) @(negedge CLOCK_50);
    issue(1'b0, 1'b1, 200, 50, 'h778899, n2);
    wait_done("q_paint1", 100, d1, bok);
    check("q_done1_cycle", d1 - n0, 65);
    check("q_paint1_first_cycle", first_cyc - n0, 1);
    check("q_paint1_nwrites", nwr, 64);
    nwr = 0;
    wait_done("q_paint2", 100, d2, bok);
    check("q_done2_cycle", d2 - n0, 130);
    check("q_paint2_first_cycle", first_cyc - n0, 66);
    check("q_paint2_first_addr", first_addr, 8100);
    check("q_paint2_nwrites", nwr, 64);
    nwr = 0;

    // The pending clear follows; abort it asynchronously near address 1000.
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLOCK_50);
      if (fb_we && fb_addr >= 17'd1000) begin
        hit = 1;
        break;
      end
    end
    check("clr_reached_1000", hit, 1);
    check("clr_first_cycle", first_cyc - n0, 131);
    check("clr_first_addr", first_addr, 0);
    #2 reset = 1'b1;
    #1;
    check("async_we", int'(fb_we), 0);
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("async_addr", int'(fb_addr), 0);
    sb.delete();
    @(negedge CLOCK_50);
    check("async_no_done", int'(done), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    v = '{cx: 0, cy: 0, col: 'h0000FF, first: 0, n: 64};
    run_paint("post_reset", v);

    // Full clear with a simultaneous paint: clear wins, the paint is dropped.
    nwr = 0;
    push_clear(76800);
    issue(1'b1, 1'b1, 40, 40, 'hFFFFFF, n0);
    wait_done("clear", 77000, d1, bok);
    check("clear_done_cycle", d1 - n0, 76801);
    check("clear_busy_high", bok, 1);
    check("clear_nwrites", nwr, 76800);
    check("clear_first_addr", first_addr, 0);
    check("clear_first_cycle", first_cyc - n0, 1);
    repeat (100) @(negedge CLOCK_50);
    check("arb_no_paint_writes", nwr, 76800);
    check("arb_busy_idle", int'(busy), 0);
    check("clear_sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
